// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared types and constants for the sequential divider
package div_pkg;

    localparam int DIV_WIDTH_DEFAULT = 32;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } div_state_t;

    // Bits needed to count down from value-1 to zero.
    function automatic int clog2(input int value);
        int bits;
        bits = 0;
        while ((1 << bits) < value) begin
            bits = bits + 1;
        end
        return bits;
    endfunction

endpackage

// File: rtl/seq_divider_if.sv
// rtl/seq_divider_if.sv - operand and result handshakes of the divider
interface seq_divider_if import div_pkg::*; #(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero
    );

endinterface

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring-division iteration
module div_step import div_pkg::*; #(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] r,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] r_next,
    output logic [WIDTH-1:0] q_next
);

    logic [WIDTH:0] trial;

    // Extra MSB acts as the borrow: set means the partial remainder is below d.
    assign trial = {r, q[WIDTH-1]} - {1'b0, d};

    always_comb begin
        r_next = {r[WIDTH-2:0], q[WIDTH-1]};
        q_next = {q[WIDTH-2:0], 1'b0};
        if (!trial[WIDTH]) begin
            r_next = trial[WIDTH-1:0];
            q_next = {q[WIDTH-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - multi-cycle unsigned restoring divider with valid/ready ports
module seq_divider import div_pkg::*; #(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic          clk,
    input  logic          rst_n,
    seq_divider_if.slave  bus
);

    localparam int CW = clog2(WIDTH);

    div_state_t       state_q;
    div_state_t       state_d;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] d_q;
    logic [WIDTH-1:0] q_step;
    logic [WIDTH-1:0] r_step;
    logic [CW-1:0]    cnt_q;
    logic             dbz_q;
    logic             accept;

    assign accept = (state_q == IDLE) && bus.in_valid;

    div_step #(.WIDTH(WIDTH)) u_step (
        .r      (r_q),
        .q      (q_q),
        .d      (d_q),
        .r_next (r_step),
        .q_next (q_step)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    state_d = (bus.divisor == '0) ? DONE : CALC;
                end
            end
            CALC: begin
                if (cnt_q == '0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Divide-by-zero skips CALC entirely, so its result is loaded at accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q   <= '0;
            r_q   <= '0;
            d_q   <= '0;
            cnt_q <= '0;
            dbz_q <= 1'b0;
        end else if (accept) begin
            d_q   <= bus.divisor;
            cnt_q <= CW'(WIDTH - 1);
            if (bus.divisor == '0) begin
                q_q   <= '1;
                r_q   <= bus.dividend;
                dbz_q <= 1'b1;
            end else begin
                q_q   <= bus.dividend;
                r_q   <= '0;
                dbz_q <= 1'b0;
            end
        end else if (state_q == CALC) begin
            q_q   <= q_step;
            r_q   <= r_step;
            cnt_q <= cnt_q - CW'(1);
        end
    end

    assign bus.quotient    = q_q;
    assign bus.remainder   = r_q;
    assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - scoreboard bench for seq_divider
module tb_seq_divider;
    import div_pkg::*;

    localparam int W = 32;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   n_recv = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    seq_divider_if #(.WIDTH(W)) bus ();

    seq_divider #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        e.a = a;
        e.b = b;
        if (b == '0) begin
            e.q = '1;
            e.r = a;
            e.z = 1'b1;
        end else begin
            e.q = a / b;
            e.r = a % b;
            e.z = 1'b0;
        end
        return e;
    endfunction

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input bit track);
        int waited = 0;
        bus.dividend = a;
        bus.divisor  = b;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && waited < 200) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!bus.in_ready) begin
            check("send_timeout", 0, 1);
            bus.in_valid = 1'b0;
            return;
        end
        if (track) sb.push_back(model(a, b));
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.dividend = $urandom;
        bus.divisor  = $urandom;
    endtask

    task automatic wait_valid(output bit ok);
        int waited = 0;
        while (!bus.out_valid && waited < 200) begin
            @(posedge clk); #1;
            waited++;
        end
        ok = bus.out_valid;
        if (!ok) check("valid_timeout", 0, 1);
    endtask

    task automatic measure_latency(output int lat);
        lat = 1;
        while (!bus.out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic receive(input int stall);
        bit   ok;
        exp_t e;
        wait_valid(ok);
        if (!ok) return;
        repeat (stall) begin
            @(posedge clk); #1;
        end
        if (sb.size() == 0) begin
            check("unexpected_result", 1, 0);
        end else begin
            e = sb.pop_front();
            check("quotient", bus.quotient, e.q);
            check("remainder", bus.remainder, e.r);
            check("div_by_zero", bus.div_by_zero, e.z);
            if (!e.z) begin
                check("invariant", {32'b0, bus.quotient} * {32'b0, e.b} + {32'b0, bus.remainder}, {32'b0, e.a});
                check("rem_lt_div", bus.remainder < e.b, 1);
            end
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        n_recv++;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, bus.in_ready, 1);
        check({tag, "_out_valid"}, bus.out_valid, 0);
        check({tag, "_quotient"}, bus.quotient, 0);
        check({tag, "_remainder"}, bus.remainder, 0);
        check({tag, "_dbz"}, bus.div_by_zero, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat;
        bit ok;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;

        send(32'd100, 32'd7, 1'b1);
        measure_latency(lat);
        check("latency_100_7", lat, 33);
        receive(0);

        send(32'hFFFF_FFFF, 32'd1, 1'b1);
        receive(0);
        send(32'd5, 32'd9, 1'b1);
        receive(0);

        send(32'd1234, 32'd0, 1'b1);
        measure_latency(lat);
        check("latency_div0", lat, 1);
        receive(0);

        // Result held under back-pressure while fresh operands are offered.
        send(32'd50, 32'd6, 1'b1);
        wait_valid(ok);
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = 1'b1;
            bus.dividend = 32'd77;
            bus.divisor  = 32'd5;
            @(posedge clk); #1;
            check("bp_quotient", bus.quotient, 8);
            check("bp_remainder", bus.remainder, 2);
            check("bp_out_valid", bus.out_valid, 1);
            check("bp_in_ready", bus.in_ready, 0);
        end
        receive(0);
        bus.in_valid = 1'b0;
        check("bp_after_in_ready", bus.in_ready, 1);
        check("bp_after_out_valid", bus.out_valid, 0);
        @(posedge clk); #1;
        check("bp_ignored_in_ready", bus.in_ready, 1);

        send(32'd200, 32'd3, 1'b0);
        repeat (10) begin
            @(posedge clk); #1;
        end
        check("calc_in_ready", bus.in_ready, 0);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midcalc");
        @(posedge clk); #1;
        rst_n = 1'b1;
        send(32'd9, 32'd4, 1'b1);
        receive(0);

        n_recv = 0;
        fork
            begin
                for (int i = 0; i < 256; i++) begin
                    logic [W-1:0] a;
                    logic [W-1:0] b;
                    a = $urandom;
                    b = $urandom >> $urandom_range(0, 31);
                    if ($urandom_range(0, 15) == 0) b = '0;
                    send(a, b, 1'b1);
                end
            end
            begin
                for (int j = 0; j < 256; j++) begin
                    receive($urandom_range(0, 3));
                end
            end
        join
        check("scoreboard_empty", sb.size(), 0);
        check("results_received", n_recv, 256);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
